// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the rate-1/2 K=3 Viterbi decoder: symbol load, ACS/survivor strobes,
// backward traceback and forward-order output. Optional VIT_TAIL_STRIP_EN drops the 2 flush bits.
module viterbi_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int AW        = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [1:0]    sym_i,
  input  logic          sym_valid_i,
  output logic          sym_ready_o,
  output logic [1:0]    piso_data_o,
  output logic          pm_clr_o,
  output logic          acs_en_o,
  output logic          sm_wr_en_o,
  output logic [AW-1:0] sm_addr_o,
  output logic          tb_en_o,
  output logic          tb_first_o,
  input  logic          tb_bit_i,
  output logic          dec_bit_o,
  output logic          dec_valid_o,
  input  logic          dec_ready_i,
  output logic          dec_last_o,
  output logic          busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_TRACE = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
`ifdef VIT_TAIL_STRIP_EN
  localparam logic [AW-1:0] OUT_LAST = AW'(FRAME_LEN - 3);
`else
  localparam logic [AW-1:0] OUT_LAST = AW'(FRAME_LEN - 1);
`endif

  logic [2:0]           state_q,   state_d;
  logic [AW-1:0]        in_cnt_q,  in_cnt_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [1:0]           piso_q,    piso_d;
  logic                 acc_q,     acc_d;
  logic [AW-1:0]        tb_cnt_q,  tb_cnt_d;
  logic [AW-1:0]        out_idx_q, out_idx_d;
  logic [FRAME_LEN-1:0] buf_q,     buf_d;

  logic accept;
  assign accept = (state_q == S_LOAD) && sym_valid_i;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    wr_addr_d = wr_addr_q;
    piso_d    = piso_q;
    tb_cnt_d  = tb_cnt_q;
    out_idx_d = out_idx_q;
    buf_d     = buf_q;
    acc_d     = accept;

    case (state_q)
      S_IDLE: begin
        if (sym_valid_i) state_d = S_CLR;
      end
      S_CLR: begin
        in_cnt_d  = '0;
        out_idx_d = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          piso_d    = sym_i;
          wr_addr_d = in_cnt_q;
          // Hold the counter on the last index instead of wrapping when FRAME_LEN == 2**AW.
          if (in_cnt_q == LAST_IDX) state_d = S_LAST;
          else                      in_cnt_d = in_cnt_q + AW'(1);
        end
      end
      S_LAST: begin
        tb_cnt_d = LAST_IDX;
        state_d  = S_TRACE;
      end
      S_TRACE: begin
        buf_d[tb_cnt_q] = tb_bit_i;
        if (tb_cnt_q == '0) state_d  = S_OUT;
        else                tb_cnt_d = tb_cnt_q - AW'(1);
      end
      S_OUT: begin
        if (dec_ready_i) begin
          if (out_idx_q == OUT_LAST) begin
            out_idx_d = '0;
            state_d   = S_IDLE;
          end else begin
            out_idx_d = out_idx_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the reversal buffer is reset with the rest so no stale bits survive an aborted frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      wr_addr_q <= '0;
      piso_q    <= '0;
      acc_q     <= 1'b0;
      tb_cnt_q  <= '0;
      out_idx_q <= '0;
      buf_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      wr_addr_q <= wr_addr_d;
      piso_q    <= piso_d;
      acc_q     <= acc_d;
      tb_cnt_q  <= tb_cnt_d;
      out_idx_q <= out_idx_d;
      buf_q     <= buf_d;
    end
  end

  assign sym_ready_o = (state_q == S_LOAD);
  assign pm_clr_o    = (state_q == S_CLR);
  assign piso_data_o = piso_q;
  assign acs_en_o    = acc_q;
  assign sm_wr_en_o  = acc_q;
  assign tb_en_o     = (state_q == S_TRACE);
  assign tb_first_o  = tb_en_o && (tb_cnt_q == LAST_IDX);
  // Write strobe and traceback never overlap: LAST separates the two phases.
  assign sm_addr_o   = acc_q ? wr_addr_q : (tb_en_o ? tb_cnt_q : '0);
  assign dec_valid_o = (state_q == S_OUT);
  assign dec_bit_o   = dec_valid_o && buf_q[out_idx_q];
  assign dec_last_o  = dec_valid_o && (out_idx_q == OUT_LAST);
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: reset abort sequence, table of directed frames and
// random frames checked against a frame-level model (accept list, trace order, output bits).
module tb_viterbi_ctrl;

  localparam int FRAME_LEN = 16;
  localparam int AW        = 4;
`ifdef VIT_TAIL_STRIP_EN
  localparam int NOUT = FRAME_LEN - 2;
`else
  localparam int NOUT = FRAME_LEN;
`endif

  logic          clk_i;
  logic          rst_ni;
  logic [1:0]    sym_i;
  logic          sym_valid_i;
  logic          sym_ready_o;
  logic [1:0]    piso_data_o;
  logic          pm_clr_o;
  logic          acs_en_o;
  logic          sm_wr_en_o;
  logic [AW-1:0] sm_addr_o;
  logic          tb_en_o;
  logic          tb_first_o;
  logic          tb_bit_i;
  logic          dec_bit_o;
  logic          dec_valid_o;
  logic          dec_ready_i;
  logic          dec_last_o;
  logic          busy_o;

  logic [15:0] tb_pat;
  logic [15:0] all_outs;

  viterbi_ctrl #(.FRAME_LEN(FRAME_LEN), .AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sym_i(sym_i), .sym_valid_i(sym_valid_i),
    .sym_ready_o(sym_ready_o), .piso_data_o(piso_data_o), .pm_clr_o(pm_clr_o),
    .acs_en_o(acs_en_o), .sm_wr_en_o(sm_wr_en_o), .sm_addr_o(sm_addr_o),
    .tb_en_o(tb_en_o), .tb_first_o(tb_first_o), .tb_bit_i(tb_bit_i),
    .dec_bit_o(dec_bit_o), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_last_o(dec_last_o), .busy_o(busy_o)
  );

  // Traceback unit stand-in: the decoded bit for an address is a fixed per-frame pattern.
  assign tb_bit_i = tb_pat[sm_addr_o];
  assign all_outs = {sym_ready_o, piso_data_o, pm_clr_o, acs_en_o, sm_wr_en_o, sm_addr_o,
                     tb_en_o, tb_first_o, dec_bit_o, dec_valid_o, dec_last_o, busy_o};

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    string       name;
    int          gap;        // 0: valid always high, 1: valid on every third cycle
    int          stall_at;   // output index to stall on, -1 for none
    int          stall_len;
    bit          rnd;        // random valid/ready/pattern
    bit          b2b;        // expect CLR exactly 2 cycles after the previous final handshake
    logic [15:0] pat;
    int          exp_nbits;
    int          exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int c = 0;
  int last_hs = -1;
  bit prev_acc = 0;
  int prev_idx = 0;
  logic [1:0] prev_sym = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  function automatic bit next_valid(input vec_t t);
    if (t.rnd)          return $urandom_range(0, 3) != 0;
    else if (t.gap == 1) return (c % 3) == 0;
    else                return 1'b1;
  endfunction

  task automatic run_frame(input vec_t t);
    int n_acc = 0, last_acc = -1, n_clr = 0, n_tb = 0, out_n = 0, done = -1;
    int stall_cnt = 0, budget = 0;
    bit seen_dv = 0, pv = 0, pr = 0, pdb = 0, pdl = 0, v, r;
    logic [1:0] s;
    logic [15:0] pat;
    pat = t.rnd ? 16'($urandom) : t.pat;
    tb_pat = pat;
    forever begin
      @(negedge clk_i);
      c++;
      budget++;
      if (budget > 600) begin
        check({t.name, "_timeout"}, 1, 0);
        break;
      end
      check("acs_en", acs_en_o, prev_acc);
      check("sm_wr_en", sm_wr_en_o, prev_acc);
      if (prev_acc) begin
        check("wr_addr", sm_addr_o, prev_idx);
        check("piso_data", piso_data_o, prev_sym);
      end else if (!tb_en_o) begin
        check("addr_idle_zero", sm_addr_o, 0);
      end
      if (pm_clr_o) begin
        n_clr++;
        check("clr_before_load", n_acc, 0);
        if (t.b2b && last_hs >= 0) check("b2b_clr_gap", c - last_hs, 2);
      end
      if (n_acc == FRAME_LEN && done < 0) check("no_ready_after_load", sym_ready_o, 0);
      if (tb_en_o) begin
        check("tb_addr", sm_addr_o, FRAME_LEN - 1 - n_tb);
        check("tb_first", tb_first_o, n_tb == 0);
        check("tb_timing", c - last_acc, 2 + n_tb);
        n_tb++;
      end else if (tb_first_o) begin
        check("tb_first_idle", tb_first_o, 0);
      end
      if (dec_valid_o) begin
        if (!seen_dv) begin
          check({t.name, "_latency"}, c - last_acc, t.exp_lat);
          seen_dv = 1;
        end
        check("dec_bit", dec_bit_o, (out_n < 16) ? pat[out_n] : 1'b0);
        check("dec_last", dec_last_o, out_n == t.exp_nbits - 1);
        if (pv && !pr) begin
          check("hold_bit", dec_bit_o, pdb);
          check("hold_last", dec_last_o, pdl);
        end
      end else if (pv && !pr) begin
        check("hold_valid", dec_valid_o, 1);
      end
      if (done >= 0) begin
        check("idle_after_frame", busy_o, 0);
        check({t.name, "_clr_count"}, n_clr, 1);
        check({t.name, "_accepts"}, n_acc, FRAME_LEN);
        check({t.name, "_trace_steps"}, n_tb, FRAME_LEN);
        check({t.name, "_bits_out"}, out_n, t.exp_nbits);
      end

      v = next_valid(t);
      s = 2'($urandom);
      if (t.rnd) r = $urandom_range(0, 1) != 0;
      else begin
        r = 1'b1;
        if (dec_valid_o && out_n == t.stall_at && stall_cnt < t.stall_len) begin
          r = 1'b0;
          stall_cnt++;
        end
      end
      sym_valid_i = v;
      sym_i       = s;
      dec_ready_i = r;

      prev_acc = sym_ready_o && v;
      if (prev_acc) begin
        if (n_acc >= FRAME_LEN) check("extra_accept", n_acc, FRAME_LEN - 1);
        prev_idx = n_acc;
        prev_sym = s;
        n_acc++;
        last_acc = c;
      end
      if (dec_valid_o && r) begin
        if (dec_last_o || out_n >= t.exp_nbits - 1) begin
          done    = c;
          last_hs = c;
        end
        out_n++;
      end
      pv  = dec_valid_o;
      pr  = r;
      pdb = dec_bit_o;
      pdl = dec_last_o;
      if (done >= 0 && done != c) break;
    end
  endtask

  vec_t vecs[8];
  int   n_seen;

  initial begin
    vecs[0] = '{"full_frame",   0, -1, 0, 1'b0, 1'b0, 16'hAAAA, NOUT, FRAME_LEN + 2};
    vecs[1] = '{"input_gaps",   1, -1, 0, 1'b0, 1'b0, 16'h5A3C, NOUT, FRAME_LEN + 2};
    vecs[2] = '{"backpressure", 0,  4, 3, 1'b0, 1'b0, 16'hC3E1, NOUT, FRAME_LEN + 2};
    vecs[3] = '{"b2b_first",    0, -1, 0, 1'b0, 1'b0, 16'h0F0F, NOUT, FRAME_LEN + 2};
    vecs[4] = '{"b2b_second",   0, -1, 0, 1'b0, 1'b1, 16'h9669, NOUT, FRAME_LEN + 2};
    for (int i = 5; i < 8; i++)
      vecs[i] = '{"random", 0, -1, 0, 1'b1, 1'b0, 16'h0000, NOUT, FRAME_LEN + 2};

    rst_ni      = 1'b0;
    sym_valid_i = 1'b0;
    sym_i       = '0;
    dec_ready_i = 1'b0;
    tb_pat      = '0;
    repeat (2) @(negedge clk_i);
    check("reset_outputs", all_outs, 0);
    rst_ni = 1'b1;

    // Abort a frame after 5 accepts while its 5th ACS strobe is on the wire.
    sym_valid_i = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 20 && n_seen < 5; i++) begin
      @(negedge clk_i);
      if (sym_ready_o) n_seen++;
    end
    check("reset_test_accepts", n_seen, 5);
    @(posedge clk_i);
    #2;
    check("pre_reset_acs", acs_en_o, 1);
    rst_ni = 1'b0;
    #1;
    check("reset_mid_frame_outputs", all_outs, 0);
    check("reset_mid_frame_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post_reset_idle_ready", sym_ready_o, 0);
    check("post_reset_idle_clr", pm_clr_o, 0);
    @(negedge clk_i);
    check("post_reset_clr_ready", sym_ready_o, 0);
    check("post_reset_clr_pulse", pm_clr_o, 1);
    @(negedge clk_i);
    check("post_reset_load_ready", sym_ready_o, 1);
    sym_valid_i = 1'b0;
    rst_ni      = 1'b0;
    @(negedge clk_i);
    rst_ni   = 1'b1;
    prev_acc = 0;
    last_hs  = -1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Frame sequencer for the rate-1/2, K=3, 4-state Viterbi decoder. It accepts received 2-bit symbols over a valid/ready handshake and feeds them to the BMU. It then pulses the ACS and survivor-memory write enables, runs a backward traceback over the survivor memory, and buffers the traced bits so they leave in forward order on a valid/ready output.

## Interface
- FRAME_LEN, 16: symbol pairs per frame, including the 2 encoder flush symbols; legal range 4 ≤ FRAME_LEN ≤ 2**AW
- AW, 4: survivor-memory address width
- clk_i  in  1  single clock; all logic on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- sym_i  in  2  received symbol pair
- sym_valid_i  in  1  sym_i valid
- sym_ready_o  out  1  controller can accept a symbol
- piso_data_o  out  2  registered symbol driven to the BMU
- pm_clr_o  out  1  one-cycle path-metric clear at frame start
- acs_en_o  out  1  ACS update strobe for piso_data_o
- sm_wr_en_o  out  1  survivor-memory write strobe
- sm_addr_o  out  AW  survivor-memory address: write address in the load phase, read address in the trace phase
- tb_en_o  out  1  traceback step enable
- tb_first_o  out  1  first traceback step, start from state 0
- tb_bit_i  in  1  decoded bit returned by the traceback unit for the current sm_addr_o
- dec_bit_o  out  1  decoded bit
- dec_valid_o  out  1  dec_bit_o valid
- dec_ready_i  in  1  sink accepts dec_bit_o
- dec_last_o  out  1  last bit of the frame, qualified by dec_valid_o
- busy_o  out  1  state is not IDLE

## Operation
- **IDLE**
  - sym_ready_o=0.
  - Moves to CLR when sym_valid_i=1.
- **CLR**
  - One cycle with pm_clr_o=1.
  - Input counter cleared; next state is LOAD.
- **LOAD**
  - sym_ready_o=1.
  - Accept when sym_valid_i & sym_ready_o. An accept registers sym_i into piso_data_o and the index into the write address.
  - On the last accept (index FRAME_LEN-1) the next state is LAST.
- **LAST**
  - One cycle with sym_ready_o=0; it carries the ACS/write strobe for the final symbol.
  - Next state is TRACE.
- **ACS/write strobes**
  - acs_en_o and sm_wr_en_o are registered "accepted in the previous cycle" flags, independent of state.
  - In the cycle after symbol k is accepted: acs_en_o=1, sm_wr_en_o=1, sm_addr_o=k, piso_data_o=symbol k.
- **TRACE**
  - FRAME_LEN cycles with tb_en_o=1; sm_addr_o counts FRAME_LEN-1 down to 0.
  - tb_first_o=1 on the first TRACE cycle only.
  - tb_bit_i is captured into reversal buffer buf[sm_addr_o] each cycle.
  - After address 0 the next state is OUT.
- **OUT**
  - dec_valid_o=1 and dec_bit_o=buf[out_idx], with out_idx starting at 0.
  - out_idx advances on dec_valid_o & dec_ready_i.
  - dec_last_o=1 when out_idx equals the final index.
  - The handshake on the final index returns the block to IDLE.
- **Arithmetic**
  - Counters are AW bits wide and never wrap within a frame.
  - sm_addr_o is 0 whenever neither strobe nor tb_en_o is active.

## Timing
- **Reset**
  - All outputs are 0, state is IDLE, all counters are 0 and buf is 0.
  - Reset asserted mid-frame abandons the frame immediately; no partial output is produced.
- **Throughput:** one symbol per cycle in LOAD; back-to-back accepts give consecutive acs_en_o pulses.
- **Latency:** with the last accept at cycle t, LAST is at t+1, TRACE spans t+2 … t+FRAME_LEN+1, and dec_valid_o first rises at t+FRAME_LEN+2.
- **Output backpressure:** while dec_valid_o=1 and dec_ready_i=0, dec_bit_o and dec_last_o hold stable.
- **Inputs ignored outside their phases**
  - sym_valid_i in IDLE only triggers CLR; a symbol is never accepted in IDLE, CLR, LAST, TRACE or OUT, and the source must hold it.
  - dec_ready_i is ignored outside OUT.
- **Back-to-back frames:** the frame end always passes through IDLE, so the next frame begins at least 2 cycles after the final output handshake (IDLE, then CLR).
- **busy_o:** combinational from state.

## Configuration
- VIT_TAIL_STRIP_EN defined:
  - The 2 flush bits (buf[FRAME_LEN-2], buf[FRAME_LEN-1]) are not emitted.
  - OUT emits FRAME_LEN-2 bits, and dec_last_o marks index FRAME_LEN-3.
  - TRACE is unchanged.
- Not defined: all FRAME_LEN bits are emitted, and dec_last_o marks index FRAME_LEN-1.

## Test plan
- **Reset mid-frame:** assert rst_ni=0 after 5 accepts.
  - Required: all outputs 0 and busy_o=0.
  - Required after release: sym_ready_o stays 0 until CLR has completed.
- **Full frame, FRAME_LEN=16, macro off:** sym_valid_i held high; tb_bit_i = sm_addr_o[0].
  - Load phase: pm_clr_o pulses once; 16 consecutive acs_en_o pulses with sm_addr_o 0..15.
  - Trace phase: sm_addr_o 15..0 with tb_first_o on the 15.
  - Output: bits 0,1,0,1,…,1 with dec_last_o on the 16th bit; first dec_valid_o arrives 18 cycles after the last accept.
- **Input gaps:** sym_valid_i toggles 1,0,0,1,….
  - Required: acs_en_o only in cycles following accepts.
  - Required: write addresses stay contiguous 0..15.
- **Output backpressure:** dec_ready_i=0 for 3 cycles at out_idx=4.
  - Required: dec_bit_o=buf[4] and dec_valid_o=1 held for all 3 cycles.
  - Required: no bit skipped or duplicated.
- **VIT_TAIL_STRIP_EN defined:** same stimulus as the full-frame test.
  - Required: exactly 14 bits emitted, with dec_last_o on the 14th.
- **Two frames back-to-back:** sym_valid_i held high throughout.
  - Required: no accepts during LAST, TRACE or OUT.
  - Required: the second pm_clr_o pulse comes 2 cycles after the last output handshake.
  - Required: second-frame addresses restart at 0.
